// File: rtl/perf_counter_reader_pkg.sv
// DebugTypes: shared performance-counter types and sizes for the debug counter reader
// Provides the named counter struct, an indexable array view of it, the index type and the reader FSM states.
package DebugTypes;
  localparam int NUM_PERF_COUNTERS = 7;
  localparam int PERF_COUNTER_WIDTH = 32;
  typedef logic [2:0] PerfCounterIndexPath;
  typedef logic [PERF_COUNTER_WIDTH-1:0] PerfCounterDataPath;
  // First field is the MSB slice, so index 0 (numLoadMiss) lands in the lowest bits of the array view.
  typedef struct packed {
    PerfCounterDataPath numBranchPredMissDetectedOnDecode;
    PerfCounterDataPath numBranchPredMiss;
    PerfCounterDataPath numMemDepPredMiss;
    PerfCounterDataPath numStoreLoadForwardingFail;
    PerfCounterDataPath numIC_Miss;
    PerfCounterDataPath numStoreMiss;
    PerfCounterDataPath numLoadMiss;
  } PerfCounterPath;
  typedef logic [NUM_PERF_COUNTERS-1:0][PERF_COUNTER_WIDTH-1:0] PerfCounterArray;
  typedef enum logic {IDLE, SEND} ReaderState;
endpackage

// File: rtl/perf_counter_reader_snapshot.sv
// perf_counter_snapshot: snapshot/baseline register pair with a modular delta selector
// clk, rst: clock and synchronous active-high reset (clears both registers)
// capture: load live into snapshot, moving the old snapshot into the baseline
// live: counter vector; idx: entry selector; delta: 1 = snapshot minus baseline, 0 = snapshot
// data: selected value
module perf_counter_snapshot #(
  parameter int N = 7,
  parameter int W = 32,
  parameter int IW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic [N-1:0][W-1:0] live,
  input  logic [IW-1:0]       idx,
  input  logic                delta,
  output logic [W-1:0]        data
);
  logic [N-1:0][W-1:0] snap, prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      prev <= '0;
    end else if (capture) begin
      prev <= snap;
      snap <= live;
    end
  end
  // W-bit subtraction wraps naturally, so a counter overflow still gives the true delta.
  assign data = delta ? snap[idx] - prev[idx] : snap[idx];
endmodule

// File: rtl/perf_counter_reader.sv
// perf_counter_reader: snapshots the performance counters on request and streams them out one entry per handshake
// clk, rst: clock and synchronous active-high reset
// perfCounter: live counters; reqValid/reqDelta/reqReady: snapshot request (delta or absolute)
// outValid/outReady/outIndex/outData/outLast: entry stream; busy: stream in progress
module perf_counter_reader #(
  parameter int NUM_PERF_COUNTERS = DebugTypes::NUM_PERF_COUNTERS,
  parameter int PERF_COUNTER_WIDTH = DebugTypes::PERF_COUNTER_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  DebugTypes::PerfCounterPath     perfCounter,
  input  logic                           reqValid,
  input  logic                           reqDelta,
  output logic                           reqReady,
  output logic                           outValid,
  input  logic                           outReady,
  output DebugTypes::PerfCounterIndexPath outIndex,
  output logic [PERF_COUNTER_WIDTH-1:0]  outData,
  output logic                           outLast,
  output logic                           busy
);
  DebugTypes::ReaderState state;
  DebugTypes::PerfCounterIndexPath idx;
  logic mode;
  logic at_last;
  logic [NUM_PERF_COUNTERS-1:0][PERF_COUNTER_WIDTH-1:0] live;
  assign live = perfCounter;
  assign at_last = idx == DebugTypes::PerfCounterIndexPath'(NUM_PERF_COUNTERS - 1);
  assign reqReady = state == DebugTypes::IDLE;
  assign busy = state == DebugTypes::SEND;
  assign outValid = busy;
  assign outIndex = idx;
  assign outLast = busy && at_last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DebugTypes::IDLE;
      idx <= '0;
      mode <= 1'b0;
    end else if (state == DebugTypes::IDLE) begin
      if (reqValid) begin
        state <= DebugTypes::SEND;
        idx <= '0;
        mode <= reqDelta;
      end
    end else if (outReady) begin
      state <= at_last ? DebugTypes::IDLE : DebugTypes::SEND;
      idx <= at_last ? idx : idx + 3'd1;
    end
  end
  perf_counter_snapshot #(
    .N (NUM_PERF_COUNTERS),
    .W (PERF_COUNTER_WIDTH),
    .IW($bits(DebugTypes::PerfCounterIndexPath))
  ) u_snapshot (
    .clk    (clk),
    .rst    (rst),
    .capture(reqValid && reqReady),
    .live   (live),
    .idx    (idx),
    .delta  (mode),
    .data   (outData)
  );
endmodule
